// File: rtl/fft_peak_reader.sv
// fft_peak_reader: sweeps the FFT result RAM over a bin range, streams |re|+|im| per bin and reports the peak bin/magnitude.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse, accepted only when idle
//   bin_lo, bin_hi      inclusive sweep range, latched at start
//   rd_addr_fft         RAM read address
//   ram_q               RAM data {re, im}, both signed DATA_W
//   busy                sweep in progress
//   mag_valid/bin/out   per-bin magnitude stream
//   done                one-cycle completion pulse
//   peak_bin, peak_mag  strongest bin of the last sweep
//   range_err           last start had bin_lo > bin_hi
module fft_peak_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   bin_lo,
    input  logic [ADDR_W-1:0]   bin_hi,
    output logic [ADDR_W-1:0]   rd_addr_fft,
    input  logic [2*DATA_W-1:0] ram_q,
    output logic                busy,
    output logic                mag_valid,
    output logic [ADDR_W-1:0]   mag_bin,
    output logic [DATA_W:0]     mag_out,
    output logic                done,
    output logic [ADDR_W-1:0]   peak_bin,
    output logic [DATA_W:0]     peak_mag,
    output logic                range_err
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] hi_q;
    logic [2:0]        cnt;
    logic              first;
    logic [RD_LAT-1:0] tag_v;
    logic [ADDR_W-1:0] tag_b [RD_LAT];
    logic [DATA_W:0]   mag_d;

    // Sign-extend by one bit before negating so -2^(DATA_W-1) maps to +2^(DATA_W-1).
    function automatic logic [DATA_W:0] abs_c(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] e;
        e = {v[DATA_W-1], v};
        return v[DATA_W-1] ? -e : e;
    endfunction

    assign mag_d = abs_c(ram_q[2*DATA_W-1:DATA_W]) + abs_c(ram_q[DATA_W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi_q        <= '0;
            cnt         <= '0;
            first       <= 1'b0;
            rd_addr_fft <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mag_valid   <= 1'b0;
            mag_bin     <= '0;
            mag_out     <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            range_err   <= 1'b0;
            tag_v       <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_b[i] <= '0;
        end else begin
            done <= 1'b0;
            // The first sample of a sweep seeds the peak, so an all-zero spectrum reports bin_lo.
            if (mag_valid && (first || mag_out > peak_mag)) begin
                peak_mag <= mag_out;
                peak_bin <= mag_bin;
            end
            if (mag_valid) first <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    hi_q     <= bin_hi;
                    peak_mag <= '0;
                    first    <= 1'b1;
                    busy     <= 1'b1;
                    if (bin_lo <= bin_hi) begin
                        state       <= ISSUE;
                        rd_addr_fft <= bin_lo;
                        peak_bin    <= '0;
                        range_err   <= 1'b0;
                    end else begin
                        state     <= DONE;
                        peak_bin  <= bin_lo;
                        range_err <= 1'b1;
                    end
                end
                ISSUE: if (rd_addr_fft == hi_q) begin
                    state <= DRAIN;
                    cnt   <= '0;
                end else begin
                    rd_addr_fft <= rd_addr_fft + ADDR_W'(1);
                end
                DRAIN: if (cnt == 3'(RD_LAT - 1)) state <= DONE;
                       else cnt <= cnt + 3'd1;
                default: begin
                    // done is registered, so it rises as busy falls, one cycle after the last magnitude.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
            tag_v[0]  <= (state == ISSUE);
            tag_b[0]  <= rd_addr_fft;
            mag_valid <= tag_v[RD_LAT-1];
            if (tag_v[RD_LAT-1]) begin
                mag_bin <= tag_b[RD_LAT-1];
                mag_out <= mag_d;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_reader.sv
// tb_fft_peak_reader: directed checks of fft_peak_reader against a 2-cycle-latency RAM model.
module tb_fft_peak_reader;
    localparam int AW = 10;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst_n, start, busy, mag_valid, done, range_err;
    logic [AW-1:0] bin_lo, bin_hi, rd_addr_fft, mag_bin, peak_bin;
    logic [2*DW-1:0] ram_q;
    logic [DW:0] mag_out, peak_mag;

    logic [2*DW-1:0] mem [1024];
    logic [AW-1:0] ar;

    int checks = 0;
    int errors = 0;
    int edges, nv, order_bad, addr_bad, last_mag, nd, nm;
    logic got_done, busy_at_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ar    <= rd_addr_fft;
        ram_q <= mem[ar];
    end

    fft_peak_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_lo(bin_lo), .bin_hi(bin_hi),
        .rd_addr_fft(rd_addr_fft), .ram_q(ram_q), .busy(busy), .mag_valid(mag_valid),
        .mag_bin(mag_bin), .mag_out(mag_out), .done(done), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .range_err(range_err)
    );

    function automatic logic [2*DW-1:0] pk(input int re, input int im);
        logic [DW-1:0] r, i;
        r = DW'(re);
        i = DW'(im);
        return {r, i};
    endfunction

    task automatic fill(input int re, input int im);
        for (int i = 0; i < 1024; i++) mem[i] = pk(re, im);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Starts a sweep and follows it cycle by cycle; edges counts clock edges since start was sampled.
    task automatic sweep(input int lo, input int hi, input int dup, input int limit);
        int n;
        @(negedge clk);
        bin_lo = AW'(lo);
        bin_hi = AW'(hi);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = hi - lo + 1;
        edges = 0; nv = 0; order_bad = 0; addr_bad = 0; last_mag = 0;
        got_done = 1'b0; busy_at_done = 1'b1;
        forever begin
            @(negedge clk);
            if (mag_valid) begin
                if (int'(mag_bin) != lo + nv) order_bad++;
                nv++;
                last_mag = int'(mag_out);
            end
            if (edges < n && int'(rd_addr_fft) != lo + edges) addr_bad++;
            if (done) begin
                got_done = 1'b1;
                busy_at_done = busy;
                break;
            end
            if (edges >= limit) break;
            if (edges == dup) begin
                start  = 1'b1;
                bin_lo = AW'(50);
                bin_hi = AW'(60);
            end
            @(posedge clk);
            #1 start = 1'b0;
            edges++;
        end
    endtask

    task automatic watch(input int cycles);
        nd = 0;
        nm = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) nd++;
            if (mag_valid) nm++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bin_lo = '0; bin_hi = '0;
        fill(3, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, mag_valid, done, range_err}, 0);
        chk("rst_addr", rd_addr_fft, 0);
        chk("rst_mag", {mag_bin, mag_out}, 0);
        chk("rst_peak", {peak_bin, peak_mag}, 0);
        rst_n = 1'b1;

        mem[37] = pk(1000, -500);
        sweep(0, 1023, -1, 5000);
        chk("tone_done", got_done, 1);
        chk("tone_edges", edges, 1027);
        chk("tone_nvalid", nv, 1024);
        chk("tone_order", order_bad, 0);
        chk("tone_addr", addr_bad, 0);
        chk("tone_busy_at_done", busy_at_done, 0);
        chk("tone_peak_bin", peak_bin, 37);
        chk("tone_peak_mag", peak_mag, 1500);
        chk("tone_range_err", range_err, 0);

        fill(3, 3);
        mem[10] = pk(-8192, -8192);
        mem[20] = pk(-8192, -8192);
        sweep(0, 511, -1, 5000);
        chk("tie_edges", edges, 515);
        chk("tie_peak_bin", peak_bin, 10);
        chk("tie_peak_mag", peak_mag, 16384);
        chk("tie_range_err", range_err, 0);

        mem[5] = pk(-1, 2);
        sweep(5, 5, -1, 5000);
        chk("single_edges", edges, 4);
        chk("single_nvalid", nv, 1);
        chk("single_mag", last_mag, 3);
        chk("single_peak", {peak_bin, peak_mag}, {10'd5, 15'd3});

        sweep(9, 3, -1, 50);
        chk("err_done", got_done, 1);
        chk("err_edges", edges, 1);
        chk("err_nvalid", nv, 0);
        chk("err_range_err", range_err, 1);
        chk("err_peak", {peak_bin, peak_mag}, {10'd9, 15'd0});

        fill(3, 3);
        mem[70] = pk(100, 100);
        sweep(0, 99, 5, 5000);
        chk("dup_edges", edges, 103);
        chk("dup_addr", addr_bad, 0);
        chk("dup_nvalid", nv, 100);
        chk("dup_peak", {peak_bin, peak_mag}, {10'd70, 15'd200});
        watch(10);
        chk("dup_extra_done", nd, 0);

        fill(3, 3);
        mem[100] = pk(4000, 4000);
        mem[800] = pk(0, -3000);
        sweep(0, 1023, -1, 300);
        chk("abort_no_done", got_done, 0);
        chk("abort_addr", rd_addr_fft, 300);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ctrl", {busy, mag_valid, done, range_err}, 0);
        chk("abort_rd_addr", rd_addr_fft, 0);
        chk("abort_mag", {mag_bin, mag_out}, 0);
        chk("abort_peak", {peak_bin, peak_mag}, 0);
        rst_n = 1'b1;
        watch(20);
        chk("abort_quiet", {nd[15:0], nm[15:0]}, 0);
        sweep(0, 1023, -1, 5000);
        chk("rerun_edges", edges, 1027);
        chk("rerun_peak", {peak_bin, peak_mag}, {10'd100, 15'd8000});

        sweep(512, 1023, -1, 5000);
        chk("b2b_edges", edges, 515);
        chk("b2b_nvalid", nv, 512);
        chk("b2b_order", order_bad, 0);
        chk("b2b_peak", {peak_bin, peak_mag}, {10'd800, 15'd3000});
        chk("b2b_range_err", range_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_peak_reader.md
Name: fft_peak_reader

Overview:
- Reader on the far side of the per-channel FFT result RAM.
- After a channel's FFT results are written, it sweeps the RAM read port over a bin range and computes an approximate magnitude per bin as |re| + |im|.
- Streams per-bin magnitudes downstream and reports the peak bin and peak magnitude.
- Feeds the localizer stage with the dominant-frequency bin per channel.

Parameters:
- ADDR_W, 10: RAM address width; 1024-point spectrum.
- DATA_W, 14: width of each signed real/imag component.
- RD_LAT, 2: RAM read latency in cycles, address-to-q; registered address and registered output. Legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begin a sweep. Sampled only in IDLE.
- bin_lo  in  ADDR_W  first bin of the sweep; latched at start.
- bin_hi  in  ADDR_W  last bin of the sweep, inclusive; latched at start.
- rd_addr_fft  out  ADDR_W  read address to the FFT result RAM.
- ram_q  in  2*DATA_W  RAM data. Real part in [27:14], imag part in [13:0], both signed.
- busy  out  1  high from the cycle after start is accepted until done.
- mag_valid  out  1  per-bin stream strobe.
- mag_bin  out  ADDR_W  bin index of mag_out.
- mag_out  out  DATA_W+1  |re| + |im| for mag_bin.
- done  out  1  one-cycle pulse; sweep complete.
- peak_bin  out  ADDR_W  bin with the largest magnitude; held until the next accepted start.
- peak_mag  out  DATA_W+1  magnitude at peak_bin; held likewise.
- range_err  out  1  set when bin_lo > bin_hi at start; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: rd_addr_fft, busy, mag_valid, mag_bin, mag_out, done, peak_bin, peak_mag, range_err.
  - The valid/tag pipeline is cleared.
  - Reset mid-sweep aborts the sweep with no done pulse; results are zeroed.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - rd_addr_fft holds its last value.
  - On start=1, latch bin_lo/bin_hi and clear peak_mag, peak_bin and range_err.
  - If bin_lo <= bin_hi: go to ISSUE with rd_addr_fft = bin_lo.
  - Else: set range_err=1 and go to DONE with peak_bin = bin_lo and peak_mag = 0.
- ISSUE:
  - One address per cycle. rd_addr_fft increments by 1 each cycle until it equals bin_hi.
  - That cycle issues the last address; next state is DRAIN.
  - bin_lo == bin_hi gives exactly one ISSUE cycle.
- DRAIN: stays exactly RD_LAT cycles, counted by a drain counter, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- start is ignored outside IDLE; no queuing.
- Tag pipeline:
  - An RD_LAT-deep shift register carries (valid, bin) alongside each issued address.
  - ram_q presented in cycle c+RD_LAT belongs to the address issued in cycle c.
- Magnitude:
  - abs() of each signed DATA_W component, zero-extended to DATA_W+1 bits, then added.
  - -8192 maps to 8192, so the maximum sum is 16384 (15 bits, no overflow).
  - mag_out, mag_bin and mag_valid are registered, one cycle after the data arrives.
- Peak tracking:
  - Update when mag_valid and mag_out > peak_mag (strict compare).
  - Ties keep the lowest bin.
  - An all-zero spectrum gives peak_bin = bin_lo, because the first sample initialises the peak unconditionally.
- Latency:
  - With N = bin_hi - bin_lo + 1 and start sampled at edge 0, done is high in the cycle after edge N+RD_LAT+1.
  - The last mag_valid occurs in the cycle before done.
  - peak_bin/peak_mag are final when done is high.

Test Plan:
- Tone test.
  - Stimulus: RAM bin 37 = {re=1000, im=-500}; all other bins = {3, 3}; bin_lo=0, bin_hi=1023, RD_LAT=2.
  - Response: peak_bin=37, peak_mag=1500; exactly 1024 mag_valid strobes with mag_bin 0..1023 in order; done exactly 1027 edges after start.
- Tie plus extreme values.
  - Stimulus: bins 10 and 20 both = {-8192, -8192}; range 0..511.
  - Response: peak_bin=10, peak_mag=16384, range_err=0.
- Single-bin and error ranges.
  - Stimulus A: bin_lo = bin_hi = 5 with bin 5 = {-1, 2}. Response: one mag_valid, mag_out=3, done 4 edges after start.
  - Stimulus B: bin_lo=9, bin_hi=3. Response: done on the next cycle, range_err=1, peak_bin=9, peak_mag=0, no mag_valid.
- Start during busy.
  - Stimulus: second start pulse 5 cycles into a sweep of 0..99.
  - Response: ignored; one done pulse only; rd_addr_fft sequence 0..99 unbroken.
- Reset mid-sweep.
  - Stimulus: rst_n=0 for one edge at address 300 of a 0..1023 sweep.
  - Response: all outputs 0, no done pulse. A subsequent start of 0..1023 completes normally with the correct peak.
- Back-to-back sweeps.
  - Stimulus: start again the cycle after done, range 512..1023.
  - Response: accepted; peak cleared; the result reflects only bins 512..1023.
